// File: rtl/lorenz_pkg.sv
// Shared constants, types and helpers for the Lorenz keystream cipher.
// Q16.16 attractor constants, fixed-point geometry and the keystream fold.
package lorenz_pkg;

  localparam int DATA_W   = 8;
  localparam int STATE_W  = 32;
  localparam int FRAC     = 16;
  localparam int DT_SHIFT = 8;
  localparam int CNT_W    = 20;
  localparam int N_PIXELS = 786432;

  typedef logic signed [STATE_W-1:0] q_t;

  localparam q_t ONE   = 32'sh0001_0000;
  localparam q_t SIGMA = 32'sh000A_0000;
  localparam q_t RHO   = 32'sh001C_0000;
  localparam q_t BETA  = 32'sh0002_AAAB;

  typedef struct packed {
    q_t x;
    q_t y;
    q_t z;
  } lz_state_t;

  // Keystream byte: bits [15:8] of each coordinate,
  // i.e. the top fractional byte, folded by XOR.
  function automatic logic [DATA_W-1:0] ks_fold(
    input lz_state_t s
  );
    return s.x[FRAC-1 -: DATA_W]
         ^ s.y[FRAC-1 -: DATA_W]
         ^ s.z[FRAC-1 -: DATA_W];
  endfunction

endpackage

// File: rtl/lorenz_axis_if.sv
// Valid/ready byte stream between keystream generator and encryptor.
// Ports: tdata/tvalid from master, tready from slave.
interface lorenz_axis_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/lorenz_keystream_gen.sv
// Lorenz attractor keystream source: Euler-stepped Q16.16 state, key
// injection into x, stream master. Ports: clk, rst, key_valid, key_in, ks.
module lorenz_keystream_gen
  import lorenz_pkg::*;
#(
  parameter int DATA_W   = lorenz_pkg::DATA_W,
  parameter int FRAC     = lorenz_pkg::FRAC,
  parameter int DT_SHIFT = lorenz_pkg::DT_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_in,
  lorenz_axis_if.master     ks
);

  localparam int W2 = 2 * STATE_W;

  typedef logic signed [W2-1:0] w_t;

  lz_state_t    s;
  lz_state_t    ns;
  w_t           xw;
  w_t           yw;
  w_t           zw;
  w_t           dx;
  w_t           dy;
  w_t           dz;
  logic [STATE_W-1:0] kmask;
  logic         step;

  // Advance whenever the current byte is absent or being taken,
  // so tdata never changes under a stalled transfer.
  assign step = !ks.tvalid || ks.tready;

  always_comb begin
    xw = W2'(s.x);
    yw = W2'(s.y);
    zw = W2'(s.z);
    // Full-width products, rescaled back to Q16.16.
    dx = (W2'(SIGMA) * (yw - xw)) >>> FRAC;
    dy = ((xw * (W2'(RHO) - zw)) >>> FRAC) - yw;
    dz = ((xw * yw) >>> FRAC)
       - ((W2'(BETA) * zw) >>> FRAC);
    kmask = '0;
    if (key_valid) begin
      kmask[FRAC-1 -: DATA_W] = key_in;
    end
    // dt = 2^-DT_SHIFT; result wraps to state width.
    ns.x = (s.x + q_t'(dx >>> DT_SHIFT)) ^ kmask;
    ns.y = s.y + q_t'(dy >>> DT_SHIFT);
    ns.z = s.z + q_t'(dz >>> DT_SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s.x       <= ONE;
      s.y       <= ONE;
      s.z       <= ONE;
      ks.tdata  <= '0;
      ks.tvalid <= 1'b0;
    end else if (step) begin
      s         <= ns;
      ks.tdata  <= ks_fold(ns);
      ks.tvalid <= 1'b1;
    end
  end

endmodule

// File: rtl/lorenz_xor_cipher.sv
// Streaming byte cipher: pixel bytes XORed with the Lorenz keystream.
// Ports: key/pixel inputs, registered ciphertext, keystream view, done.
module lorenz_xor_cipher
  import lorenz_pkg::*;
#(
  parameter int DATA_W   = lorenz_pkg::DATA_W,
  parameter int STATE_W  = lorenz_pkg::STATE_W,
  parameter int FRAC     = lorenz_pkg::FRAC,
  parameter int DT_SHIFT = lorenz_pkg::DT_SHIFT,
  parameter int N_PIXELS = lorenz_pkg::N_PIXELS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_in,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              pixel_valid,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_out_valid,
  output logic [DATA_W-1:0] key_out,
  output logic              key_out_valid,
  output logic              done
);

  localparam logic [CNT_W-1:0] N_FULL =
    CNT_W'(N_PIXELS);
  localparam logic [CNT_W-1:0] N_LAST =
    CNT_W'(N_PIXELS - 1);

  lorenz_axis_if #(.DATA_W(DATA_W)) ks ();

  logic             xfer;
  logic [CNT_W-1:0] cnt;

  lorenz_keystream_gen #(
    .DATA_W   (DATA_W),
    .FRAC     (FRAC),
    .DT_SHIFT (DT_SHIFT)
  ) u_gen (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_in    (key_in),
    .ks        (ks.master)
  );

  // A presented pixel is the consumer's ready.
  assign ks.tready     = pixel_valid;
  assign xfer          = pixel_valid && ks.tvalid;
  assign key_out       = ks.tdata;
  assign key_out_valid = ks.tvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
    end else begin
      pixel_out_valid <= xfer;
      if (xfer) begin
        pixel_out <= pixel_in ^ ks.tdata;
      end
    end
  end

  // Counter saturates at a full frame; done is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (xfer) begin
      if (cnt != N_FULL) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (cnt == N_LAST) begin
        done <= 1'b1;
      end
    end
  end

  logic unused_state_w;
  assign unused_state_w = (STATE_W == 0);

endmodule

// File: tb/tb_lorenz_xor_cipher.sv
// Scoreboard bench for lorenz_xor_cipher against a Lorenz reference model.
// Frame length shortened to 16 bytes to reach done quickly.
module tb_lorenz_xor_cipher;

  localparam int NPIX = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic [7:0] pixel_in = 8'h00;
  logic       pixel_valid = 1'b0;
  logic [7:0] pixel_out;
  logic       pixel_out_valid;
  logic [7:0] key_out;
  logic       key_out_valid;
  logic       done;

  lorenz_xor_cipher #(.N_PIXELS(NPIX)) dut (
    .clk             (clk),
    .rst             (rst),
    .key_valid       (key_valid),
    .key_in          (key_in),
    .pixel_in        (pixel_in),
    .pixel_valid     (pixel_valid),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .key_out         (key_out),
    .key_out_valid   (key_out_valid),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    byte unsigned d;
    bit           dn;
  } exp_t;

  exp_t         sb[$];
  byte unsigned cap[$];
  int           checks = 0;
  int           fails = 0;

  // Reference model: real Lorenz arithmetic on 64-bit integers.
  longint       mx, my, mz;
  byte unsigned mcur;
  bit           mvalid;
  int           mcnt;

  bit           kvs[2048];
  byte unsigned kbs[2048];

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic longint w32(longint v);
    int t;
    t = int'(v);
    return longint'(t);
  endfunction

  function automatic void m_reset();
    mx = 64'h10000;
    my = 64'h10000;
    mz = 64'h10000;
    mcur = 0;
    mvalid = 0;
    mcnt = 0;
  endfunction

  function automatic void m_step(bit kv, byte unsigned k);
    longint dx, dy, dz, nx, ny, nz;
    longint sig, rho, bet;
    sig = 64'h000A0000;
    rho = 64'h001C0000;
    bet = 64'h0002AAAB;
    dx = (sig * (my - mx)) >>> 16;
    dy = ((mx * (rho - mz)) >>> 16) - my;
    dz = ((mx * my) >>> 16) - ((bet * mz) >>> 16);
    nx = w32(mx + (dx >>> 8));
    ny = w32(my + (dy >>> 8));
    nz = w32(mz + (dz >>> 8));
    if (kv) nx = nx ^ (longint'(k) << 8);
    mx = nx;
    my = ny;
    mz = nz;
    mcur = byte'((nx >>> 8) ^ (ny >>> 8) ^ (nz >>> 8));
    mvalid = 1;
  endfunction

  // One clock: present inputs, update model, advance to posedge+1.
  task automatic cycle(bit pv, byte unsigned pin, bit kv,
                       byte unsigned kin, output bit took);
    exp_t e;
    took = 0;
    if (mvalid) begin
      chk("key_out", key_out, mcur);
      chk("key_out_valid", key_out_valid, 1);
    end else begin
      chk("key_out_valid_low", key_out_valid, 0);
    end
    pixel_valid = pv;
    pixel_in = pin;
    key_valid = kv;
    key_in = kin;
    if (!mvalid) begin
      m_step(kv, kin);
    end else if (pv) begin
      if (mcnt < NPIX) mcnt++;
      e.d = pin ^ mcur;
      e.dn = (mcnt >= NPIX);
      sb.push_back(e);
      m_step(kv, kin);
      took = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit t;
    repeat (2) cycle(0, 0, 0, 0, t);
    chk("drained", sb.size(), 0);
  endtask

  task automatic do_reset(bit mid);
    if (mid) #2;
    else #5;
    rst = 0;
    pixel_valid = 0;
    key_valid = 0;
    #1;
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_pixel_out_valid", pixel_out_valid, 0);
    chk("rst_key_out", key_out, 0);
    chk("rst_key_out_valid", key_out_valid, 0);
    chk("rst_done", done, 0);
    if (!mid) chk("sb_empty", sb.size(), 0);
    sb.delete();
    cap.delete();
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1;
  endtask

  task automatic send(input byte unsigned src[$], input int mode);
    int i, c;
    bit took, kv;
    byte unsigned k;
    i = 0;
    c = 0;
    while (i < src.size() && c < src.size() + 8) begin
      case (mode)
        0: begin kv = 0; k = 0; end
        1: begin kv = 1; k = 8'h5A; end
        default: begin kv = kvs[c]; k = kbs[c]; end
      endcase
      cycle(1, src[i], kv, k, took);
      if (took) i++;
      c++;
    end
    if (i < src.size()) chk("send_timeout", i, src.size());
    drain();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && pixel_out_valid) begin
      cap.push_back(pixel_out);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out: got 0x%0h expected none",
                 pixel_out);
      end else begin
        e = sb.pop_front();
        chk("pixel_out", pixel_out, e.d);
        chk("done", done, e.dn);
      end
    end
  end

  initial begin
    byte unsigned zeros[$];
    byte unsigned ramp[$];
    byte unsigned ct[$];
    byte unsigned ks_a[$];
    byte unsigned ks_b[$];
    int nd;
    bit t;

    for (int i = 0; i < 2048; i++) begin
      kvs[i] = bit'($urandom_range(0, 1));
      kbs[i] = byte'($urandom);
    end
    for (int i = 0; i < 1000; i++) zeros.push_back(0);
    for (int i = 0; i < 256; i++) ramp.push_back(byte'(i));

    m_reset();
    do_reset(0);

    // First keystream byte and hold while not ready.
    cycle(0, 0, 0, 0, t);
    chk("first_ks", key_out, 8'hE4);
    repeat (3) cycle(0, 0, 1, 8'h33, t);
    chk("ks_hold", key_out, 8'hE4);
    cycle(1, 8'h00, 0, 0, t);
    chk("px00", pixel_out, 8'hE4);
    chk("px00_valid", pixel_out_valid, 1);
    drain();

    do_reset(0);
    cycle(0, 0, 0, 0, t);
    cycle(1, 8'hFF, 0, 0, t);
    chk("pxFF", pixel_out, 8'h1B);
    drain();

    // Unkeyed run twice (reproducibility), then keyed run.
    do_reset(0);
    send(zeros, 0);
    ks_a = cap;
    do_reset(0);
    send(zeros, 0);
    chk("rep_size", cap.size(), ks_a.size());
    nd = 0;
    for (int i = 0; i < cap.size() && i < ks_a.size(); i++)
      if (cap[i] != ks_a[i]) nd++;
    chk("reproducible", nd, 0);
    do_reset(0);
    send(zeros, 1);
    ks_b = cap;
    nd = 0;
    for (int i = 0; i < ks_b.size() && i < ks_a.size(); i++)
      if (ks_b[i] != ks_a[i]) nd++;
    chk("keyed_differs", nd > 0, 1);

    // Round trip: encrypting the ciphertext recovers the ramp.
    do_reset(0);
    send(ramp, 2);
    ct = cap;
    chk("ct_size", ct.size(), 256);
    do_reset(0);
    send(ct, 2);
    chk("rt_size", cap.size(), 256);
    nd = 0;
    for (int i = 0; i < cap.size(); i++)
      if (cap[i] != byte'(i)) nd++;
    chk("round_trip", nd, 0);

    // Random traffic with gaps and sporadic keys.
    do_reset(0);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, byte'($urandom),
            bit'($urandom_range(0, 1)), byte'($urandom), t);
    drain();

    // done boundary.
    do_reset(0);
    cycle(0, 0, 0, 0, t);
    for (int i = 0; i < NPIX - 1; i++)
      cycle(1, byte'($urandom), 0, 0, t);
    chk("done_before", done, 0);
    cycle(1, 8'h42, 0, 0, t);
    chk("done_rise", done, 1);
    chk("done_rise_valid", pixel_out_valid, 1);
    repeat (3) cycle(0, 0, 0, 0, t);
    chk("done_idle", done, 1);
    repeat (5) cycle(1, byte'($urandom), 0, 0, t);
    chk("done_more", done, 1);
    drain();

    // Asynchronous reset in the middle of a stream.
    do_reset(0);
    for (int i = 0; i < 20; i++)
      cycle(1, byte'($urandom), 1, byte'($urandom), t);
    do_reset(1);
    cycle(0, 0, 0, 0, t);
    chk("restart_ks", key_out, 8'hE4);
    cycle(1, 8'h00, 0, 0, t);
    chk("restart_px", pixel_out, 8'hE4);
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
